// File: rtl/pixel_interp_pipe_if.sv
// rtl/pixel_interp_pipe_if.sv - window-in / pixel-out stream bundle for pixel_interp_pipe
interface pixel_interp_pipe_if #(
    parameter int PIX_W  = 8,
    parameter int CH     = 1,
    parameter int FRAC_W = 4
) ();
    logic                  s_valid;
    logic                  s_ready;
    logic [CH*PIX_W-1:0]   p0;
    logic [CH*PIX_W-1:0]   p1;
    logic [CH*PIX_W-1:0]   p2;
    logic [CH*PIX_W-1:0]   p3;
    logic [FRAC_W-1:0]     fx;
    logic [FRAC_W-1:0]     fy;
    logic                  mode;
    logic                  m_valid;
    logic                  m_ready;
    logic [CH*PIX_W-1:0]   m_pix;

    modport slave (
        input  s_valid, p0, p1, p2, p3, fx, fy, mode, m_ready,
        output s_ready, m_valid, m_pix
    );

    modport master (
        output s_valid, p0, p1, p2, p3, fx, fy, mode, m_ready,
        input  s_ready, m_valid, m_pix
    );
endinterface

// File: rtl/pixel_interp_pipe.sv
// rtl/pixel_interp_pipe.sv - 3-stage 2x2 rounded-average / bilinear pixel interpolator
// Optional output-transfer counter (pix_cnt, cnt_clr) enabled by PIXEL_INTERP_PIXCNT_EN.
module pixel_interp_pipe #(
    parameter int PIX_W  = 8,
    parameter int CH     = 1,
    parameter int FRAC_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    pixel_interp_pipe_if.slave bus
`ifdef PIXEL_INTERP_PIXCNT_EN
    ,
    input  logic              cnt_clr,
    output logic [31:0]       pix_cnt
`endif
);
    localparam int DW = CH * PIX_W;
    localparam int SW = PIX_W + 2;
    localparam int TW = PIX_W + FRAC_W;
    localparam int AW = PIX_W + 2 * FRAC_W + 1;
    localparam int QW = PIX_W + 1;

    localparam logic [TW-1:0] WONE_T = TW'(1) << FRAC_W;
    localparam logic [AW-1:0] WONE_A = AW'(1) << FRAC_W;
    localparam logic [AW-1:0] RND    = AW'(1) << (2 * FRAC_W - 1);

    logic en1, en2, en3;
    logic v1, v2, v3;

    logic              mode1;
    logic [FRAC_W-1:0] fy1;
    logic [CH*SW-1:0]  sum1;
    logic [CH*TW-1:0]  top1, bot1;

    logic              mode2;
    logic [DW-1:0]     avg2;
    logic [CH*QW-1:0]  q2;

    logic [DW-1:0]     pix3;

    logic [CH*SW-1:0]  s1_sum;
    logic [CH*TW-1:0]  s1_top, s1_bot;
    logic [DW-1:0]     s2_avg;
    logic [CH*QW-1:0]  s2_q;
    logic [DW-1:0]     s3_pix;

    logic [TW-1:0]     wx, wx_n;
    logic [AW-1:0]     wy, wy_n;

    // Ready ripples back from the output; a stage may load whenever its content leaves.
    assign en3 = !v3 || bus.m_ready;
    assign en2 = !v2 || en3;
    assign en1 = !v1 || en2;

    assign bus.s_ready = en1;
    assign bus.m_valid = v3;
    assign bus.m_pix   = pix3;

    assign wx   = TW'(bus.fx);
    assign wx_n = WONE_T - wx;
    assign wy   = AW'(fy1);
    assign wy_n = WONE_A - wy;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [TW-1:0] a0, a1, a2, a3;
        logic [AW-1:0] top_c, bot_c;

        assign a0 = TW'(bus.p0[c*PIX_W +: PIX_W]);
        assign a1 = TW'(bus.p1[c*PIX_W +: PIX_W]);
        assign a2 = TW'(bus.p2[c*PIX_W +: PIX_W]);
        assign a3 = TW'(bus.p3[c*PIX_W +: PIX_W]);

        assign s1_sum[c*SW +: SW] = SW'(bus.p0[c*PIX_W +: PIX_W]) + SW'(bus.p1[c*PIX_W +: PIX_W])
                                  + SW'(bus.p2[c*PIX_W +: PIX_W]) + SW'(bus.p3[c*PIX_W +: PIX_W]);
        assign s1_top[c*TW +: TW] = a0 * wx_n + a1 * wx;
        assign s1_bot[c*TW +: TW] = a2 * wx_n + a3 * wx;

        assign top_c = AW'(top1[c*TW +: TW]);
        assign bot_c = AW'(bot1[c*TW +: TW]);

        // Only the integer part plus one overflow bit of the accumulator is carried forward.
        assign s2_q[c*QW +: QW]      = QW'((top_c * wy_n + bot_c * wy + RND) >> (2 * FRAC_W));
        assign s2_avg[c*PIX_W +: PIX_W] = PIX_W'((sum1[c*SW +: SW] + SW'(2)) >> 2);

        assign s3_pix[c*PIX_W +: PIX_W] = !mode2            ? avg2[c*PIX_W +: PIX_W] :
                                          q2[c*QW + PIX_W]  ? {PIX_W{1'b1}} :
                                                              q2[c*QW +: PIX_W];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            mode1 <= 1'b0;
            fy1   <= '0;
            sum1  <= '0;
            top1  <= '0;
            bot1  <= '0;
        end else if (en1) begin
            v1 <= bus.s_valid;
            if (bus.s_valid) begin
                mode1 <= bus.mode;
                fy1   <= bus.fy;
                sum1  <= s1_sum;
                top1  <= s1_top;
                bot1  <= s1_bot;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            mode2 <= 1'b0;
            avg2  <= '0;
            q2    <= '0;
        end else if (en2) begin
            v2 <= v1;
            if (v1) begin
                mode2 <= mode1;
                avg2  <= s2_avg;
                q2    <= s2_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v3   <= 1'b0;
            pix3 <= '0;
        end else if (en3) begin
            v3 <= v2;
            if (v2) begin
                pix3 <= s3_pix;
            end
        end
    end

`ifdef PIXEL_INTERP_PIXCNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_cnt <= '0;
        end else if (cnt_clr) begin
            pix_cnt <= '0;
        end else if (v3 && bus.m_ready) begin
            pix_cnt <= pix_cnt + 32'd1;
        end
    end
`endif
endmodule
